// File: rtl/rv64g_reg_scoreboard.sv
// -----------------------------------------------------------------------------
// rv64g_reg_scoreboard
//
// Per-register write-lock scoreboard between decode and launch. Each
// architectural register (GPRs 0..31, FPRs at 32 + fN) has a saturating lock
// counter. This allows several in-flight writers to the same destination. A
// global counter bounds the total number of live locks to NUM_OUTSTANDING.
// Issue is gated combinationally on RAW hazards against source registers, on a
// full scoreboard, and on a saturated destination counter. Writeback releases
// one lock per cycle.
//
// Register x0 is never locked and never released.
//
// Optional feature (macro RV64G_REG_SCOREBOARD_BYPASS_EN):
//   When defined, a legal same-cycle release is forwarded into the issue check.
//   A source whose last lock is being released does not cause a hazard.
//   A full scoreboard with a legal release in the same cycle still accepts a
//   writer.
//
// Ports:
//   clk_i            clock, rising edge
//   rst_i            synchronous active-high reset
//   issue_valid_i    decoded instruction presented for issue
//   issue_ready_o    scoreboard accepts the instruction this cycle
//   issue_src_req_i  source-register bitmap of the presented instruction
//   issue_rd_we_i    presented instruction writes rd
//   issue_rd_i       destination register index
//   wb_valid_i       writeback completes; release one lock on wb_rd_i
//   wb_rd_i          released register index
//   locked_o         bit r set while register r has a live lock
//   outstanding_o    total live locks
//   err_o            sticky: release of a register with no live lock
// -----------------------------------------------------------------------------
module rv64g_reg_scoreboard #(
  parameter int NUM_REGS        = 64,
  parameter int NUM_OUTSTANDING = 7,
  parameter int CNT_W           = $clog2(NUM_OUTSTANDING + 1),
  // Derived index width; not intended to be overridden.
  parameter int IDX_W           = $clog2(NUM_REGS)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                issue_valid_i,
  output logic                issue_ready_o,
  input  logic [NUM_REGS-1:0] issue_src_req_i,
  input  logic                issue_rd_we_i,
  input  logic [IDX_W-1:0]    issue_rd_i,
  input  logic                wb_valid_i,
  input  logic [IDX_W-1:0]    wb_rd_i,
  output logic [NUM_REGS-1:0] locked_o,
  output logic [CNT_W-1:0]    outstanding_o,
  output logic                err_o
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(NUM_OUTSTANDING);
  localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

  logic [CNT_W-1:0]    cnt [NUM_REGS];
  logic [CNT_W-1:0]    total;
  logic                err;

  logic [NUM_REGS-1:0] locked_eff;
  logic [NUM_REGS-1:0] src_mask;
  logic                lock_cand;
  logic                rel_legal;
  logic                rel_bad;
  logic                hazard;
  logic                full;
  logic                sat;
  logic                ready;
  logic                do_lock;

  // Issue check (combinational, independent of issue_valid_i)
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      locked_o[r] = (cnt[r] != '0);
    end

    lock_cand = issue_rd_we_i & (issue_rd_i != '0);
    rel_legal = wb_valid_i & (wb_rd_i != '0) & (cnt[wb_rd_i] != '0);
    rel_bad   = wb_valid_i & (wb_rd_i != '0) & (cnt[wb_rd_i] == '0);

`ifdef RV64G_REG_SCOREBOARD_BYPASS_EN
    // A lock whose final count is retiring this cycle no longer blocks readers.
    for (int r = 0; r < NUM_REGS; r++) begin
      locked_eff[r] = locked_o[r] &
                      ~(wb_valid_i & (wb_rd_i == IDX_W'(r)) & (cnt[r] == ONE_CNT));
    end
    full = lock_cand & (total == MAX_CNT) & ~rel_legal;
`else
    locked_eff = locked_o;
    full       = lock_cand & (total == MAX_CNT);
`endif

    // x0 is hardwired zero and can never be a RAW hazard.
    src_mask    = issue_src_req_i;
    src_mask[0] = 1'b0;
    hazard      = |(src_mask & locked_eff);
    sat         = lock_cand & (cnt[issue_rd_i] == MAX_CNT);
    ready       = ~hazard & ~full & ~sat;
    do_lock     = issue_valid_i & ready & lock_cand;
  end

  // Lock-counter update: lock and release on the same register cancel out.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt[r] <= '0;
      end
      total <= '0;
      err   <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        unique case ({do_lock & (issue_rd_i == IDX_W'(r)),
                      rel_legal & (wb_rd_i == IDX_W'(r))})
          2'b10:   cnt[r] <= cnt[r] + ONE_CNT;
          2'b01:   cnt[r] <= cnt[r] - ONE_CNT;
          default: cnt[r] <= cnt[r];
        endcase
      end
      if (do_lock & ~rel_legal) begin
        total <= total + ONE_CNT;
      end else if (rel_legal & ~do_lock) begin
        total <= total - ONE_CNT;
      end
      if (rel_bad) begin
        err <= 1'b1;
      end
    end
  end

  assign issue_ready_o = ready;
  assign outstanding_o = total;
  assign err_o         = err;

endmodule

// File: tb/tb_rv64g_reg_scoreboard.sv
module tb_rv64g_reg_scoreboard;

  localparam int NR   = 64;
  localparam int NOUT = 7;
  localparam int CW   = $clog2(NOUT + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          issue_valid;
  logic          issue_ready;
  logic [NR-1:0] issue_src_req;
  logic          issue_rd_we;
  logic [5:0]    issue_rd;
  logic          wb_valid;
  logic [5:0]    wb_rd;
  logic [NR-1:0] locked;
  logic [CW-1:0] outstanding;
  logic          err;

  rv64g_reg_scoreboard dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .issue_valid_i   (issue_valid),
    .issue_ready_o   (issue_ready),
    .issue_src_req_i (issue_src_req),
    .issue_rd_we_i   (issue_rd_we),
    .issue_rd_i      (issue_rd),
    .wb_valid_i      (wb_valid),
    .wb_rd_i         (wb_rd),
    .locked_o        (locked),
    .outstanding_o   (outstanding),
    .err_o           (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            chk;
    bit            rdy;
    logic [NR-1:0] lck;
    int            outs;
    bit            err;
  } exp_t;

  exp_t q[$];
  int   ncmp  = 0;
  int   nfail = 0;

  // Reference model: plain integer lock counts per register.
  int mcnt[NR];
  int mtot = 0;
  bit merr = 1'b0;

  // One clock of stimulus. The expected response is queued here; the monitor
  // checks it separately.
  task automatic cyc(input bit r, input bit v, input logic [NR-1:0] src,
                     input bit we, input int rd, input bit wbv, input int wbrd,
                     input bit chk);
    exp_t e;
    bit   hz, writer, rel_ok, fl, st;
    @(negedge clk);
    #1;
    rst           = r;
    issue_valid   = v;
    issue_src_req = src;
    issue_rd_we   = we;
    issue_rd      = 6'(rd);
    wb_valid      = wbv;
    wb_rd         = 6'(wbrd);

    writer = we && (rd != 0);
    rel_ok = wbv && (wbrd != 0) && (mcnt[wbrd] > 0);
    hz = 1'b0;
    for (int i = 1; i < NR; i++) begin
      if (src[i] && mcnt[i] > 0) begin
`ifdef RV64G_REG_SCOREBOARD_BYPASS_EN
        if (!(wbv && wbrd == i && mcnt[i] == 1)) hz = 1'b1;
`else
        hz = 1'b1;
`endif
      end
    end
    fl = writer && (mtot == NOUT);
`ifdef RV64G_REG_SCOREBOARD_BYPASS_EN
    if (rel_ok) fl = 1'b0;
`endif
    st = writer && (mcnt[rd] == NOUT);

    e.chk  = chk;
    e.rdy  = !(hz || fl || st);
    e.outs = mtot;
    e.err  = merr;
    for (int i = 0; i < NR; i++) e.lck[i] = (mcnt[i] > 0);
    q.push_back(e);

    // Advance the model to the state after this edge.
    if (r) begin
      for (int i = 0; i < NR; i++) mcnt[i] = 0;
      mtot = 0;
      merr = 1'b0;
    end else begin
      if (v && e.rdy && writer) begin
        mcnt[rd]++;
        mtot++;
      end
      if (wbv && wbrd != 0) begin
        if (rel_ok) begin
          mcnt[wbrd]--;
          mtot--;
        end else begin
          merr = 1'b1;
        end
      end
    end
  endtask

  task automatic idle();
    cyc(0, 0, '0, 0, 0, 0, 0, 1);
  endtask

  function automatic logic [NR-1:0] bit_of(input int i);
    logic [NR-1:0] b;
    b = '0;
    b[i] = 1'b1;
    return b;
  endfunction

  // Monitor: compares whatever the DUT presents against the queued response.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        if (e.chk) begin
          ncmp++;
          if (issue_ready !== e.rdy || locked !== e.lck ||
              int'(outstanding) != e.outs || err !== e.err) begin
            nfail++;
            $display("FAIL vec%0d t=%0t: ready=%b exp %b, locked=%h exp %h, outstanding=%0d exp %0d, err=%b exp %b",
                     ncmp, $time, issue_ready, e.rdy, locked, e.lck,
                     outstanding, e.outs, err, e.err);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rd, wbrd, pick;
    bit v, we, wbv;
    logic [NR-1:0] src;

    for (int i = 0; i < NR; i++) mcnt[i] = 0;
    rst = 1'b1; issue_valid = 1'b0; issue_src_req = '0; issue_rd_we = 1'b0;
    issue_rd = '0; wb_valid = 1'b0; wb_rd = '0;

    // Reset, then idle.
    cyc(1, 0, '0, 0, 0, 0, 0, 0);
    idle();
    idle();

    // RAW hazard on rd=5 and its release.
    cyc(0, 1, '0, 1, 5, 0, 0, 1);
    cyc(0, 1, bit_of(5), 0, 0, 0, 0, 1);
    cyc(0, 1, bit_of(5), 0, 0, 1, 5, 1);
    cyc(0, 1, bit_of(5), 0, 0, 0, 0, 1);

    // Fill the scoreboard, then probe full, non-writer and full+release.
    for (int i = 3; i <= 9; i++) cyc(0, 1, '0, 1, i, 0, 0, 1);
    cyc(0, 1, '0, 1, 10, 0, 0, 1);
    cyc(0, 1, '0, 0, 10, 0, 0, 1);
    cyc(0, 1, '0, 1, 0, 0, 0, 1);
    cyc(0, 1, '0, 1, 10, 1, 3, 1);
    for (int i = 3; i <= 10; i++) cyc(0, 0, '0, 0, 0, 1, i, 1);
    idle();

    // Two writers on an FPR, released one at a time.
    cyc(0, 1, '0, 1, 40, 0, 0, 1);
    cyc(0, 1, '0, 1, 40, 0, 0, 1);
    cyc(0, 0, '0, 0, 0, 1, 40, 1);
    cyc(0, 0, '0, 0, 0, 1, 40, 1);
    idle();

    // Same-cycle lock and release on one register.
    cyc(0, 1, '0, 1, 12, 0, 0, 1);
    cyc(0, 1, '0, 1, 12, 1, 12, 1);
    cyc(0, 0, '0, 0, 0, 1, 12, 1);
    idle();

    // Release of x0, bad release, then reset during traffic.
    cyc(0, 0, '0, 0, 0, 1, 0, 1);
    cyc(0, 0, '0, 0, 0, 1, 20, 1);
    cyc(0, 0, '0, 0, 0, 1, 0, 1);
    cyc(0, 1, '0, 1, 0, 0, 0, 1);
    cyc(0, 1, '0, 1, 33, 0, 0, 1);
    cyc(1, 1, '0, 1, 34, 1, 33, 1);
    idle();

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      v   = ($urandom_range(0, 3) != 0);
      we  = ($urandom_range(0, 4) != 0);
      rd  = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(0, NR - 1));
      src = '0;
      pick = $urandom_range(0, 3);
      for (int k = 0; k < pick; k++) src = src | bit_of($urandom_range(0, NR - 1));
      if ($urandom_range(0, 4) == 0) src = src | bit_of(rd);
      wbv  = ($urandom_range(0, 2) == 0);
      wbrd = int'($urandom_range(0, NR - 1));
      if ($urandom_range(0, 9) != 0) begin
        for (int t = 0; t < 16; t++) begin
          pick = $urandom_range(1, NR - 1);
          if (mcnt[pick] > 0) begin
            wbrd = pick;
            break;
          end
        end
      end
      cyc(($urandom_range(0, 299) == 0), v, src, we, rd, wbv, wbrd, 1);
    end

    idle();
    repeat (3) @(negedge clk);
    #3;
    ncmp++;
    if (q.size() != 0) begin
      nfail++;
      $display("FAIL drain: %0d responses left, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/rv64g_reg_scoreboard.md
Name: rv64g_reg_scoreboard

Overview:
Per-register write-lock scoreboard for the rv64g instruction launcher. It generalises the single-bit register-requirement bitmap into per-register saturating lock counters. This allows multiple in-flight writers to the same destination, bounded globally by NUM_OUTSTANDING. It sits between decode and launch: it gates issue on RAW hazards and releases locks on writeback.

Parameters:
NUM_REGS, 64, total architectural registers (GPR + FPR; FPR index = 32 + fN).
NUM_OUTSTANDING, 7, max in-flight register-writing instructions across all registers.
CNT_W, $clog2(NUM_OUTSTANDING+1), width of each per-register counter and of the total counter.

Ports:
clk_i  input  1  clock, rising edge.
rst_i  input  1  synchronous active-high reset.
issue_valid_i  input  1  decoded instruction presented for issue.
issue_ready_o  output  1  scoreboard accepts the instruction this cycle.
issue_src_req_i  input  NUM_REGS  source-register bitmap (rs1/rs2/rs3) of the presented instruction.
issue_rd_we_i  input  1  presented instruction writes rd.
issue_rd_i  input  $clog2(NUM_REGS)  destination register index.
wb_valid_i  input  1  writeback completes; release one lock on wb_rd_i.
wb_rd_i  input  $clog2(NUM_REGS)  released register index.
locked_o  output  NUM_REGS  bit r = (cnt[r] != 0).
outstanding_o  output  CNT_W  total live locks.
err_o  output  1  sticky: release of a register whose count is 0.

Behaviour:
- Reset (sync, rst_i=1 at posedge): all cnt[r]=0, total=0, err_o=0. Consequently locked_o=0, outstanding_o=0, issue_ready_o=1 when inputs are benign. rst_i overrides any same-cycle issue or wb.
- Index 0 (x0) is never locked: a lock on rd=0 performs no count and does not consume total. Release of rd=0 is ignored and does not set err.
- The locking condition is do_lock = fire & issue_rd_we_i & (issue_rd_i != 0).
- Combinational ready:
  - hazard = |(issue_src_req_i & locked_eff & ~1).
  - full = (total == NUM_OUTSTANDING) & do_lock-candidate.
  - sat = cnt[issue_rd_i] == NUM_OUTSTANDING.
  - issue_ready_o = ~hazard & ~full & ~sat.
  - issue_ready_o does not depend on issue_valid_i.
  - locked_eff = locked_o (without the optional feature).
- fire = issue_valid_i & issue_ready_o. Latency: the lock is visible on locked_o on the cycle after fire.
- Release is legal when wb_valid_i=1 & wb_rd_i != 0 & cnt[wb_rd_i] != 0. It decrements cnt[wb_rd_i] and total on the next edge.
- Release with cnt=0 (wb_rd_i != 0): no state change; err_o <= 1 and holds until reset.
- Simultaneous lock and release on the same register: the count is unchanged and total is unchanged.
- Simultaneous lock and release on different registers: one counter increments, the other decrements, and total is unchanged.
- A full scoreboard with a same-cycle release does not accept an issue (no bypass, without the feature).
- WAW is permitted: a second writer to a locked rd increments the count. The source-hazard check only ever looks at sources.
- issue_src_req_i that includes its own rd is checked against the pre-issue state only.
- Counters never wrap:
  - increment is blocked by full/sat;
  - decrement is blocked at 0 (error path).
- Non-writing instructions (issue_rd_we_i=0) need only ~hazard; full and sat are ignored for them.
- Invariant: outstanding_o == sum of cnt[r].

Optional Feature:
Macro RV64G_REG_SCOREBOARD_BYPASS_EN.
- Defined:
  - locked_eff[r] = locked_o[r] & ~(wb_valid_i & wb_rd_i==r & cnt[r]==1). A source released this cycle does not block issue.
  - full also considers a same-cycle legal release (total - 1 < NUM_OUTSTANDING), so issue proceeds.
  - The lock/release net-count rules above still apply.
- Undefined: locked_eff = locked_o; a release frees the hazard one cycle after wb_valid_i.

Test Plan:
- Reset then idle -> locked_o=0, outstanding_o=0, err_o=0, issue_ready_o=1 with issue_src_req_i=0.
- Issue rd=5 (we=1); next cycle present src_req bit5 -> issue_ready_o=0. Then wb_rd_i=5 -> ready=1 one cycle later (same cycle with BYPASS_EN).
- Issue 7 writers to rd=3,4,5,6,7,8,9 -> outstanding_o=7. 8th writer rd=10 -> ready=0; a non-writer with no hazard -> ready=1.
- Two writers to rd=40 -> locked_o[40]=1. One wb -> still locked. Second wb -> locked_o[40]=0, outstanding_o=0.
- Same-cycle issue rd=12 and wb rd=12 with cnt[12]=1 -> cnt[12]=1, outstanding_o unchanged.
- wb_rd_i=20 with cnt=0 -> err_o=1, counts unchanged. wb_rd_i=0 -> err_o unaffected. rst_i=1 mid-traffic -> all outputs back to reset values next cycle.
